core_mem: RTL
=============

Name: core_MEM

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes EX_regs_t and performs loads and stores over a req/ack data-memory bus, stalling the pipe while a transaction is outstanding.
- Handles byte-lane alignment, sign/zero extension and address-error detection, with a bus-timeout watchdog.
- Registers results into MEM_regs_t for writeback and drives MEM_data, the forwarding source used by the execute stage.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the bus error is raised; minimum 1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- EX_regs  in  EX_regs_t  execute-stage pipeline register
- flush  in  1  discard the instruction currently in MEM
- dmem_req  out  1  bus request; held with all request fields stable until dmem_ack
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  64  EX_regs.out with bits [2:0] forced to 0
- dmem_be  out  8  byte enables (stores; loads drive all ones)
- dmem_wdata  out  64  store data replicated into its lanes
- dmem_ack  in  1  single-cycle completion pulse
- dmem_rdata  in  64  load data, valid while dmem_ack=1
- mem_stall  out  1  freeze IF/ID/EX this cycle
- MEM_regs  out  MEM_regs_t  registered stage output
- MEM_data  out  64  equals MEM_regs.out (combinational copy, forwarding path)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - MEM_regs all zero; state IDLE; timeout counter 0.
  - dmem_req, dmem_we, mem_stall and dmem_be all 0.
  - Reset mid-WAIT drops dmem_req immediately; a later stray ack is ignored.
- mem_op: EX_regs.mem_load_type != MEM_NONE or EX_regs.mem_store_type != MEM_NONE.
- Size from type: BYTE=1, HALF=2, WORD=4, DWORD=8 bytes. Lane = EX_regs.out[2:0].
- Misalignment: lane is not a multiple of the size.
  - Issue no request.
  - Set MEM_regs.addr_err_load (load) or addr_err_store (store).
  - Clear write_enable; no stall.
- Store bytes: dmem_be = size-wide ones shifted left by lane; dmem_wdata = EX_regs.B_data[size*8-1:0] replicated across all lanes.
- FSM states IDLE and WAIT:
  - IDLE:
    - With an aligned mem_op and flush=0, dmem_req=1 combinationally.
    - Ack in the same cycle: complete, stay IDLE.
    - Otherwise go to WAIT and clear the counter.
  - WAIT:
    - dmem_req=1 and the counter increments each cycle.
    - On dmem_ack, complete and go to IDLE.
    - When the counter reaches TIMEOUT_CYCLES-1 without ack, drop the request, set MEM_regs.bus_err and clear write_enable; the slave must abandon a dropped request. Go to IDLE.
- mem_stall = dmem_req && !dmem_ack. Upstream advances on the ack edge, so MEM latency = 1 cycle + bus wait.
- Load completion:
  - Shift dmem_rdata right by lane*8 and truncate to size.
  - Sign-extend when EX_regs.signed_mem_out=1, else zero-extend.
  - Result goes to MEM_regs.out.
- Non-memory instructions pass through in one cycle:
  - MEM_regs.out = EX_regs.out.
  - Copy W_regnum, write_enable, pc4, linkpc, overflow, MFC0/MTC0, cp0_rd, sel, syscall and break_.
- A store completes with write_enable forced to 0.
- Flush:
  - In IDLE, MEM_regs is cleared next edge and no request is issued.
  - In WAIT, the transaction cannot be abandoned: latch flush_pending, keep the request until ack, then write zeros to MEM_regs. Stall stays asserted until ack.
- While mem_stall=1, MEM_regs holds its previous value (no bubble inserted until completion).

Decomposition:
- structures package additions:
  - mem_type_t enum (MEM_NONE, MEM_BYTE, MEM_HALF, MEM_WORD, MEM_DWORD), shared with the decoder.
  - MEM_regs_t struct.
  - mem_state_t enum (IDLE, WAIT).
- Sub-module mem_lane_align: combinational byte-enable, write-replication, load shift/extend and misalignment logic. The stage FSM and registers live in core_MEM.

Test Plan:
- Load, lane 3, ack delayed 3 cycles:
  - Stimulus: LB signed at address 0x1003, dmem_rdata=0x00000000_80000000.
  - Required: mem_stall high for exactly 3 cycles; dmem_addr=0x1000; MEM_regs.out=0xFFFFFFFF_FFFFFF80.
  - Same with LBU: out=0x80.
- SH, same-cycle ack:
  - Stimulus: address 0x2006, B_data=0x1234.
  - Required: dmem_be=8'b1100_0000, wdata=0x1234_1234_1234_1234, no stall, write_enable=0 in MEM_regs.
- Misaligned LW:
  - Stimulus: address 0x3002.
  - Required: dmem_req never rises, addr_err_load=1, write_enable=0.
- Flush in WAIT:
  - Stimulus: LD pending, flush on cycle 2, ack on cycle 4.
  - Required: req held through cycle 4, MEM_regs all zero after the ack edge.
- Timeout with TIMEOUT_CYCLES=4:
  - Stimulus: no ack.
  - Required: req drops after 4 WAIT cycles, bus_err=1, stall released.
- Reset mid-WAIT:
  - Required: req, stall and MEM_regs go to 0 asynchronously; a subsequent ack has no effect.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types for the memory-access stage: bus sizes, stage
// registers and the stage FSM encoding.
package core_mem_pkg;

  typedef enum logic [2:0] {
    MEM_NONE,
    MEM_BYTE,
    MEM_HALF,
    MEM_WORD,
    MEM_DWORD
  } mem_type_t;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  typedef struct packed {
    logic [63:0] out;
    logic [63:0] B_data;
    mem_type_t   mem_load_type;
    mem_type_t   mem_store_type;
    logic        signed_mem_out;
    logic [4:0]  W_regnum;
    logic        write_enable;
    logic [63:0] pc4;
    logic        linkpc;
    logic        overflow;
    logic        MFC0;
    logic        MTC0;
    logic [4:0]  cp0_rd;
    logic [2:0]  sel;
    logic        syscall;
    logic        break_;
  } EX_regs_t;

  typedef struct packed {
    logic [63:0] out;
    logic [4:0]  W_regnum;
    logic        write_enable;
    logic [63:0] pc4;
    logic        linkpc;
    logic        overflow;
    logic        MFC0;
    logic        MTC0;
    logic [4:0]  cp0_rd;
    logic [2:0]  sel;
    logic        syscall;
    logic        break_;
    logic        addr_err_load;
    logic        addr_err_store;
    logic        bus_err;
  } MEM_regs_t;

  function automatic logic [3:0] mem_size(mem_type_t t);
    logic [3:0] s;
    s = 4'd1;
    unique case (1'b1)
      t == MEM_HALF:  s = 4'd2;
      t == MEM_WORD:  s = 4'd4;
      t == MEM_DWORD: s = 4'd8;
      default:        s = 4'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/core_mem_lane_align.sv
// Byte-lane steering for the data bus: store enables/replication,
// load shift and extension, and natural-alignment check.
module mem_lane_align
  import core_mem_pkg::*;
(
  input  mem_type_t   load_type_i,
  input  mem_type_t   store_type_i,
  input  logic        signed_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] data_i,
  input  logic [63:0] rdata_i,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        misaligned_o,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] load_o
);

  mem_type_t   typ;
  logic [3:0]  size;
  logic [2:0]  mask;
  logic [63:0] sh;

  // a store type wins if a malformed bundle carries both
  assign is_store_o = store_type_i != MEM_NONE;
  assign is_load_o  = !is_store_o && load_type_i != MEM_NONE;
  assign typ  = is_store_o ? store_type_i : load_type_i;
  assign size = mem_size(typ);
  assign mask = size[2:0] - 3'd1;
  assign misaligned_o = (lane_i & mask) != 3'd0;
  assign sh = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    be_o    = 8'h00;
    wdata_o = '0;
    load_o  = '0;
    unique case (1'b1)
      typ == MEM_BYTE: begin
        be_o    = 8'h01 << lane_i;
        wdata_o = {8{data_i[7:0]}};
        load_o  = {{56{signed_i & sh[7]}}, sh[7:0]};
      end
      typ == MEM_HALF: begin
        be_o    = 8'h03 << lane_i;
        wdata_o = {4{data_i[15:0]}};
        load_o  = {{48{signed_i & sh[15]}}, sh[15:0]};
      end
      typ == MEM_WORD: begin
        be_o    = 8'h0F << lane_i;
        wdata_o = {2{data_i[31:0]}};
        load_o  = {{32{signed_i & sh[31]}}, sh[31:0]};
      end
      typ == MEM_DWORD: begin
        be_o    = 8'hFF;
        wdata_o = data_i;
        load_o  = sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_mem.sv
// Memory-access stage: req/ack data bus master with stall,
// flush-while-waiting and a bus-timeout watchdog.
module core_mem
  import core_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  EX_regs_t    EX_regs,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_be,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall,
  output MEM_regs_t   MEM_regs,
  output logic [63:0] MEM_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        fp_q, fp_d;
  MEM_regs_t   regs_q, regs_d;

  logic        is_load, is_store, misal;
  logic [7:0]  st_be;
  logic [63:0] st_wdata, ld_res;
  logic        aligned_op, timeout;
  MEM_regs_t   pass, done_r;

  mem_lane_align u_align (
    .load_type_i  (EX_regs.mem_load_type),
    .store_type_i (EX_regs.mem_store_type),
    .signed_i     (EX_regs.signed_mem_out),
    .lane_i       (EX_regs.out[2:0]),
    .data_i       (EX_regs.B_data),
    .rdata_i      (dmem_rdata),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .misaligned_o (misal),
    .be_o         (st_be),
    .wdata_o      (st_wdata),
    .load_o       (ld_res)
  );

  assign aligned_op = (is_load || is_store) && !misal;
  assign timeout = state_q == WAIT && cnt_q == CNT_LAST;

  // the watchdog cycle drops req so upstream advances past the op
  always_comb begin
    dmem_req = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    dmem_req = aligned_op && !flush;
        WAIT:    dmem_req = !timeout;
        default: dmem_req = 1'b0;
      endcase
    end
  end

  assign dmem_we    = dmem_req && is_store;
  assign dmem_be    = dmem_req ? (is_store ? st_be : 8'hFF) : 8'h00;
  assign dmem_wdata = st_wdata;
  assign dmem_addr  = {EX_regs.out[63:3], 3'b000};
  assign mem_stall  = dmem_req && !dmem_ack;

  always_comb begin
    pass = '0;
    pass.out          = EX_regs.out;
    pass.W_regnum     = EX_regs.W_regnum;
    pass.write_enable = EX_regs.write_enable;
    pass.pc4          = EX_regs.pc4;
    pass.linkpc       = EX_regs.linkpc;
    pass.overflow     = EX_regs.overflow;
    pass.MFC0         = EX_regs.MFC0;
    pass.MTC0         = EX_regs.MTC0;
    pass.cp0_rd       = EX_regs.cp0_rd;
    pass.sel          = EX_regs.sel;
    pass.syscall      = EX_regs.syscall;
    pass.break_       = EX_regs.break_;
    done_r = pass;
    if (is_store) done_r.write_enable = 1'b0;
    else          done_r.out = ld_res;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fp_d    = fp_q;
    regs_d  = regs_q;
    unique case (state_q)
      IDLE: begin
        fp_d = 1'b0;
        if (flush) begin
          regs_d = '0;
        end else if ((is_load || is_store) && misal) begin
          regs_d = pass;
          regs_d.write_enable   = 1'b0;
          regs_d.addr_err_load  = is_load;
          regs_d.addr_err_store = is_store;
        end else if (aligned_op) begin
          if (dmem_ack) begin
            regs_d = done_r;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else begin
          regs_d = pass;
        end
      end
      WAIT: begin
        fp_d  = fp_q | flush;
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          state_d = IDLE;
          fp_d    = 1'b0;
          regs_d  = pass;
          regs_d.write_enable = 1'b0;
          regs_d.bus_err      = 1'b1;
          if (fp_q || flush) regs_d = '0;
        end else if (dmem_ack) begin
          state_d = IDLE;
          fp_d    = 1'b0;
          regs_d  = (fp_q || flush) ? '0 : done_r;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fp_q    <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      regs_q  <= regs_d;
    end
  end

  assign MEM_regs = regs_q;
  assign MEM_data = regs_q.out;

endmodule
